// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared types, parity encodings and baud divider helper for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Rounded clock-cycles-per-bit.
    function automatic int calc_bit_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_frame_baud_tick.sv
`timescale 1ns/1ps
// Bit-period down-counter; tick marks the last clock of each bit period.
// Held at reload while restart is high, so the first period after release is a full BIT_DIV clocks.
module uart_baud_tick #(
    parameter int BIT_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(BIT_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = ~restart & (cnt == '0);

endmodule

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Rising edge of uart_en_send starts a frame; edges while busy are dropped.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_en_send,
    input  logic [7:0] uart_data,
    output logic       uart_txd,
    output logic       uart_tx_busy,
    output logic       uart_tx_done
);

    localparam int BIT_DIV = calc_bit_div(CLK_FREQ, BAUD);

    if (BIT_DIV < 2) begin : g_bad_div
        $error("uart_tx_frame: BIT_DIV must be at least 2");
    end
    if (PARITY > 2 || PARITY < 0) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    tx_state_t  state_q, state_n;
    logic       en_prev;
    logic       start;
    logic       restart;
    logic       tick;
    logic [7:0] shreg_q, shreg_n;
    logic [2:0] bit_cnt_q, bit_cnt_n;
    logic       par_q, par_n;
    logic       txd_n, busy_n, done_n;

    assign start   = uart_en_send & ~en_prev & (state_q == IDLE);
    assign restart = (state_q == IDLE);

    uart_baud_tick #(
        .BIT_DIV (BIT_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            en_prev      <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
            uart_tx_done <= 1'b0;
        end else begin
            state_q      <= state_n;
            en_prev      <= uart_en_send;
            shreg_q      <= shreg_n;
            bit_cnt_q    <= bit_cnt_n;
            par_q        <= par_n;
            uart_txd     <= txd_n;
            uart_tx_busy <= busy_n;
            uart_tx_done <= done_n;
        end
    end

    // txd_n is the level of the bit being entered, so the line is registered.
    always_comb begin
        state_n   = state_q;
        shreg_n   = shreg_q;
        bit_cnt_n = bit_cnt_q;
        par_n     = par_q;
        txd_n     = uart_txd;
        busy_n    = uart_tx_busy;
        done_n    = 1'b0;
        case (state_q)
            IDLE: begin
                txd_n  = 1'b1;
                busy_n = 1'b0;
                if (start) begin
                    state_n   = START;
                    shreg_n   = uart_data;
                    par_n     = (PARITY == PARITY_ODD) ? ~^uart_data : ^uart_data;
                    bit_cnt_n = '0;
                    txd_n     = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    txd_n     = shreg_q[0];
                    shreg_n   = {1'b0, shreg_q[7:1]};
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_n = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_n = uart_pkg::PARITY;
                            txd_n   = par_q;
                        end else begin
                            state_n = STOP;
                            txd_n   = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_q + 3'd1;
                        txd_n     = shreg_q[0];
                        shreg_n   = {1'b0, shreg_q[7:1]};
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    state_n   = STOP;
                    txd_n     = 1'b1;
                    bit_cnt_n = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        txd_n   = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
// Directed bench: four 10-clock-per-bit variants sharing stimulus plus one default-rate instance.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic       en_def;
    logic [7:0] data_def;
    logic [3:0] txd_v, busy_v, done_v;
    logic       txd_d, busy_d, done_d;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u_p0s1 (
        .clk(clk), .rst_n(rst_n), .uart_en_send(en), .uart_data(data),
        .uart_txd(txd_v[0]), .uart_tx_busy(busy_v[0]), .uart_tx_done(done_v[0]));
    uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) u_p2s1 (
        .clk(clk), .rst_n(rst_n), .uart_en_send(en), .uart_data(data),
        .uart_txd(txd_v[1]), .uart_tx_busy(busy_v[1]), .uart_tx_done(done_v[1]));
    uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u_p1s1 (
        .clk(clk), .rst_n(rst_n), .uart_en_send(en), .uart_data(data),
        .uart_txd(txd_v[2]), .uart_tx_busy(busy_v[2]), .uart_tx_done(done_v[2]));
    uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(2)) u_p0s2 (
        .clk(clk), .rst_n(rst_n), .uart_en_send(en), .uart_data(data),
        .uart_txd(txd_v[3]), .uart_tx_busy(busy_v[3]), .uart_tx_done(done_v[3]));
    uart_tx_frame u_def (
        .clk(clk), .rst_n(rst_n), .uart_en_send(en_def), .uart_data(data_def),
        .uart_txd(txd_d), .uart_tx_busy(busy_d), .uart_tx_done(done_d));

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int par_of(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int flen(input int i);
        return (10 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i) - 1) * 10;
    endfunction

    function automatic logic exp_bit(input logic [7:0] d, input int par, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9 && par != 0) return (par == 1) ? ~^d : ^d;
        return 1'b1;
    endfunction

    logic [7:0] cur_d;
    int txd_errs[4], busy_n[4], done_n[4], done_at[4];
    logic par_seen[4];

    task automatic acc(input int k);
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = (k < flen(i)) ? exp_bit(cur_d, par_of(i), k / 10) : 1'b1;
            if (txd_v[i] !== e) txd_errs[i]++;
            if (busy_v[i] === 1'b1) busy_n[i]++;
            if (done_v[i] === 1'b1) begin
                done_n[i]++;
                done_at[i] = k;
            end
            if (k == 95) par_seen[i] = txd_v[i];
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input int n, input int chg_at,
                             input int glitch_at, input int drop_at);
        en = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            txd_errs[i] = 0; busy_n[i] = 0; done_n[i] = 0; done_at[i] = -1; par_seen[i] = 1'bx;
        end
        cur_d = d;
        data  = d;
        en    = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            acc(k);
            if (k == chg_at) data = 8'hFF;
            if (glitch_at >= 0 && k == glitch_at) en = 1'b0;
            if (glitch_at >= 0 && k == glitch_at + 1) en = 1'b1;
            if (k == drop_at) en = 1'b0;
        end
        en = 1'b0;
    endtask

    int d1, d2, b2b_errs, low_run, busy_cnt, def_done_at, post_busy, post_done, post_low;
    logic low_done, txd_at_d1, busy_at_d1;

    initial begin
        rst_n = 1'b0; en = 1'b0; data = 8'h00; en_def = 1'b0; data_def = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_txd", {31'd0, txd_v[0]}, 1);
        check_val("rst_busy", {31'd0, busy_v[0]}, 0);
        check_val("rst_done", {31'd0, done_v[0]}, 0);
        check_val("rst_txd_def", {31'd0, txd_d}, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Default rate: 434 clocks per bit
        data_def = 8'hA5; en_def = 1'b1;
        low_run = 0; busy_cnt = 0; def_done_at = -1; low_done = 1'b0;
        for (int k = 0; k < 4400; k++) begin
            @(negedge clk);
            if (!low_done) begin
                if (txd_d === 1'b0) low_run++;
                else low_done = 1'b1;
            end
            if (busy_d === 1'b1) busy_cnt++;
            if (done_d === 1'b1 && def_done_at < 0) def_done_at = k;
        end
        en_def = 1'b0;
        check_val("def_bit_period", low_run, 434);
        check_val("def_busy_len", busy_cnt, 4340);
        check_val("def_done_at", def_done_at, 4340);

        // 0xA5 on all variants, request held 500 clocks, data changed after latch
        run_frame(8'hA5, 500, 20, -1, -1);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("A_txd_errs%0d", i), txd_errs[i], 0);
            check_val($sformatf("A_busy_len%0d", i), busy_n[i], flen(i));
            check_val($sformatf("A_done_cnt%0d", i), done_n[i], 1);
            check_val($sformatf("A_done_at%0d", i), done_at[i], flen(i));
        end
        check_val("A_even_parity", {31'd0, par_seen[1]}, 0);
        check_val("A_odd_parity", {31'd0, par_seen[2]}, 1);

        // Extra edge mid-frame is dropped
        run_frame(8'h5A, 150, -1, 30, 60);
        check_val("B_txd_errs0", txd_errs[0], 0);
        check_val("B_done_cnt0", done_n[0], 1);
        check_val("B_busy_len0", busy_n[0], 100);
        check_val("B_done_cnt3", done_n[3], 1);

        // Back-to-back: new edge in the done cycle
        en = 1'b0;
        repeat (3) @(negedge clk);
        data = 8'hA5; en = 1'b1;
        d1 = -1; d2 = -1; b2b_errs = 0; txd_at_d1 = 1'bx; busy_at_d1 = 1'bx;
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            if (d1 >= 0 && k > d1 && k <= d1 + 100)
                if (txd_v[0] !== exp_bit(8'h3C, 0, (k - d1 - 1) / 10)) b2b_errs++;
            if (done_v[0] === 1'b1) begin
                if (d1 < 0) begin
                    d1 = k; txd_at_d1 = txd_v[0]; busy_at_d1 = busy_v[0];
                    data = 8'h3C; en = 1'b1;
                end else if (d2 < 0) begin
                    d2 = k;
                end
            end
            if (k == 50) en = 1'b0;
        end
        en = 1'b0;
        check_val("C_done1_at", d1, 100);
        check_val("C_done_gap", d2 - d1, 101);
        check_val("C_frame2_errs", b2b_errs, 0);
        check_val("C_txd_done_cycle", {31'd0, txd_at_d1}, 1);
        check_val("C_busy_done_cycle", {31'd0, busy_at_d1}, 0);

        // Reset at clock 45 of a frame (line is low there for 0xA5)
        repeat (3) @(negedge clk);
        data = 8'hA5; en = 1'b1;
        for (int k = 0; k <= 45; k++) @(negedge clk);
        check_val("D_txd_before_rst", {31'd0, txd_v[0]}, 0);
        #2 rst_n = 1'b0;
        en = 1'b0;
        #1;
        check_val("D_txd_in_rst", {31'd0, txd_v[0]}, 1);
        check_val("D_busy_in_rst", {31'd0, busy_v[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        post_busy = 0; post_done = 0; post_low = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (busy_v[0] === 1'b1) post_busy++;
            if (done_v[0] === 1'b1) post_done++;
            if (txd_v[0] !== 1'b1) post_low++;
        end
        check_val("D_no_done", post_done, 0);
        check_val("D_no_busy", post_busy, 0);
        check_val("D_line_idle", post_low, 0);
        run_frame(8'hC3, 130, -1, -1, -1);
        check_val("D_clean_errs0", txd_errs[0], 0);
        check_val("D_clean_done_at0", done_at[0], 100);
        check_val("D_clean_done_cnt0", done_n[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
